// File: rtl/platform_irq_pkg.sv
// Shared definitions for the platform interrupt controller: register map,
// source limits and reset values.
package platform_irq_pkg;

   localparam int unsigned N_SRC_MAX = 16;
   localparam int unsigned ID_W      = $clog2(N_SRC_MAX);

   // Every source powers up in rising-edge mode.
   localparam logic [N_SRC_MAX-1:0] MODE_RESET = '1;

   typedef enum logic [2:0] {
      REG_PENDING = 3'd0,
      REG_MASK    = 3'd1,
      REG_MODE    = 3'd2,
      REG_ACTIVE  = 3'd3,
      REG_ACK     = 3'd4,
      REG_TICKS   = 3'd5,
      REG_RSVD6   = 3'd6,
      REG_RSVD7   = 3'd7
   } reg_addr_e;

endpackage

// File: rtl/platform_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller register file.
interface platform_irq_ctrl_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/platform_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the masked pending vector.
module platform_irq_prio_enc
   import platform_irq_pkg::*;
#(
   parameter int unsigned N_SRC = 8
) (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [ID_W-1:0]  id
);

   // Scan upward and keep only the first request seen.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req[i] && !valid) begin
            valid = 1'b1;
            id    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/platform_irq_ctrl.sv
// Memory-mapped interrupt controller: per-source level/edge capture, mask,
// fixed-priority active ID, combined CPU interrupt and timer tick counter.
module platform_irq_ctrl
   import platform_irq_pkg::*;
#(
   parameter int unsigned N_SRC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SRC-1:0]   irq_src,
   platform_irq_ctrl_if.slave bus,
   output logic               irq_out
);

   reg_addr_e         addr;
   logic              wr_en;
   logic              rd_en;
   logic [N_SRC-1:0]  wdata;
   logic              unused_wdata;

   logic [N_SRC-1:0]  src_prev;
   logic [N_SRC-1:0]  src_rise;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  pending_nxt;
   logic [N_SRC-1:0]  mask;
   logic [N_SRC-1:0]  mode;
   logic [N_SRC-1:0]  w1c_clr;
   logic [N_SRC-1:0]  ack_clr;
   logic [N_SRC-1:0]  enabled;
   logic [15:0]       ticks;
   logic [15:0]       rd_mux;
   logic              act_valid;
   logic [ID_W-1:0]   act_id;

   assign addr         = reg_addr_e'(bus.address);
   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign rd_en        = bus.chipselect & bus.write_n;
   assign wdata        = bus.writedata[N_SRC-1:0];
   assign unused_wdata = ^bus.writedata;

   assign src_rise = irq_src & ~src_prev;
   assign enabled  = pending & mask;

   // Per-source clear requests from a PENDING write-1-to-clear or an ACK by ID.
   always_comb begin
      w1c_clr = '0;
      ack_clr = '0;
      if (wr_en && addr == REG_PENDING) begin
         w1c_clr = wdata;
      end
      if (wr_en && addr == REG_ACK) begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (bus.writedata[3:0] == 4'(i)) begin
               ack_clr[i] = 1'b1;
            end
         end
      end
   end

   // Edge sources: a new edge beats a same-cycle clear. Level sources mirror the line.
   assign pending_nxt = (mode & (src_rise | (pending & ~(w1c_clr | ack_clr))))
                      | (~mode & irq_src);

   platform_irq_prio_enc #(
      .N_SRC (N_SRC)
   ) u_prio_enc (
      .req   (enabled),
      .valid (act_valid),
      .id    (act_id)
   );

   // Register read multiplexer; unimplemented bits and addresses read zero.
   always_comb begin
      rd_mux = '0;
      case (addr)
         REG_PENDING: rd_mux = 16'(pending);
         REG_MASK:    rd_mux = 16'(mask);
         REG_MODE:    rd_mux = 16'(mode);
         REG_ACTIVE:  rd_mux = {act_valid, 11'b0, act_id};
         REG_TICKS:   rd_mux = ticks;
         default:     rd_mux = '0;
      endcase
   end

   // Source capture, configuration registers and the combined interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_prev <= '0;
         pending  <= '0;
         mask     <= '0;
         mode     <= MODE_RESET[N_SRC-1:0];
         irq_out  <= 1'b0;
      end else begin
         src_prev <= irq_src;
         pending  <= pending_nxt;
         if (wr_en && addr == REG_MASK) begin
            mask <= wdata;
         end
         if (wr_en && addr == REG_MODE) begin
            mode <= wdata;
         end
         irq_out <= |enabled;
      end
   end

   // Timer tick counter on source 0; a bus write clears it even against a coincident tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         ticks <= '0;
      end else if (wr_en && addr == REG_TICKS) begin
         ticks <= '0;
      end else if (src_rise[0]) begin
         ticks <= ticks + 16'd1;
      end
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.readdata <= '0;
      end else if (rd_en) begin
         bus.readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_platform_irq_ctrl.sv
// Self-checking bench for platform_irq_ctrl: directed scenarios followed by
// randomized bus/source traffic, all compared against a cycle-level model.
module tb_platform_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irq_src;
   logic       irq_out;

   platform_irq_ctrl_if bus ();

   platform_irq_ctrl #(
      .N_SRC (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_src (irq_src),
      .bus     (bus),
      .irq_out (irq_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state, expressed directly from the register-map rules.
   logic [7:0]  m_pend;
   logic [7:0]  m_mask;
   logic [7:0]  m_mode;
   logic [7:0]  m_prev;
   int          m_ticks;
   logic [15:0] m_rd;
   logic        m_irq;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_active();
      for (int i = 0; i < 8; i++) begin
         if (m_pend[i] && m_mask[i]) return {1'b1, 11'b0, 4'(i)};
      end
      return 16'h0000;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {8'h00, m_pend};
         3'd1:    return {8'h00, m_mask};
         3'd2:    return {8'h00, m_mode};
         3'd3:    return m_active();
         3'd5:    return 16'(m_ticks);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic m_reset();
      m_pend  = '0;
      m_mask  = '0;
      m_mode  = 8'hFF;
      m_prev  = '0;
      m_ticks = 0;
      m_rd    = '0;
      m_irq   = 1'b0;
   endtask

   // One clock edge of the model, using the inputs present at that edge.
   task automatic m_step();
      logic       wr;
      logic [7:0] nxt;
      wr = bus.chipselect && !bus.write_n;
      if (bus.chipselect && bus.write_n) m_rd = m_read(bus.address);
      m_irq = (m_pend & m_mask) != 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (!m_mode[i]) begin
            nxt[i] = irq_src[i];
         end else if (irq_src[i] && !m_prev[i]) begin
            nxt[i] = 1'b1;
         end else if (wr && bus.address == 3'd0 && bus.writedata[i]) begin
            nxt[i] = 1'b0;
         end else if (wr && bus.address == 3'd4 && int'(bus.writedata[3:0]) == i) begin
            nxt[i] = 1'b0;
         end else begin
            nxt[i] = m_pend[i];
         end
      end
      if (wr && bus.address == 3'd5) m_ticks = 0;
      else if (irq_src[0] && !m_prev[0]) m_ticks = (m_ticks + 1) % 65536;
      if (wr && bus.address == 3'd1) m_mask = bus.writedata[7:0];
      if (wr && bus.address == 3'd2) m_mode = bus.writedata[7:0];
      m_prev = irq_src;
      m_pend = nxt;
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) m_reset();
      else m_step();
      #1;
      check("readdata", bus.readdata, m_rd);
      check("irq_out", {15'b0, irq_out}, {15'b0, m_irq});
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      step();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] v);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = a;
      step();
      bus.chipselect = 1'b0;
      v = bus.readdata;
   endtask

   task automatic pulse0();
      irq_src = 8'h01;
      step();
      irq_src = 8'h00;
      step();
   endtask

   initial begin
      logic [15:0] v;
      int          hi;

      reset          = 1'b1;
      irq_src        = 8'hFF;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
      m_reset();

      // Reset with all sources high
      step();
      step();
      check("rst_readdata", bus.readdata, 16'h0000);
      check("rst_irq_out", {15'b0, irq_out}, 16'h0000);
      reset   = 1'b0;
      irq_src = 8'h00;
      step();
      rd(3'd2, v); check("rst_mode", v, 16'h00FF);
      rd(3'd1, v); check("rst_mask", v, 16'h0000);

      // Edge capture, mask upper bits ignored, ACK by ID
      wr(3'd1, 16'hFF05);
      rd(3'd1, v); check("mask_upper_ignored", v, 16'h0005);
      irq_src = 8'h04;
      step();
      irq_src = 8'h00;
      rd(3'd0, v); check("edge_pending", v, 16'h0004);
      check("edge_irq_high", {15'b0, irq_out}, 16'h0001);
      rd(3'd3, v); check("edge_active", v, 16'h8002);
      wr(3'd4, 16'h0002);
      rd(3'd0, v); check("ack_pending", v, 16'h0000);
      check("ack_irq_low", {15'b0, irq_out}, 16'h0000);

      // Priority and W1C; ACK with out-of-range ID
      wr(3'd1, 16'h00FF);
      irq_src = 8'h48;
      step();
      irq_src = 8'h00;
      rd(3'd3, v); check("prio_active3", v, 16'h8003);
      wr(3'd0, 16'h0008);
      rd(3'd3, v); check("prio_active6", v, 16'h8006);
      wr(3'd4, 16'h000E);
      rd(3'd0, v); check("ack_out_of_range", v, 16'h0040);
      wr(3'd0, 16'h00FF);

      // Set wins over a same-cycle W1C
      irq_src = 8'h02;
      wr(3'd0, 16'h0002);
      irq_src = 8'h00;
      rd(3'd0, v); check("set_wins", v, 16'h0002);
      wr(3'd0, 16'h0002);

      // Level mode on source 0
      wr(3'd1, 16'h0001);
      wr(3'd2, 16'h00FE);
      hi = 0;
      irq_src = 8'h01;
      repeat (5) begin step(); if (irq_out) hi++; end
      irq_src = 8'h00;
      repeat (4) begin step(); if (irq_out) hi++; end
      check("level_irq_cycles", 16'(hi), 16'd5);
      rd(3'd5, v); check("level_ticks", v, 16'h0001);
      irq_src = 8'h01;
      step();
      wr(3'd0, 16'h0001);
      rd(3'd0, v); check("level_w1c_ignored", v, 16'h0001);
      irq_src = 8'h00;
      step();
      step();
      wr(3'd2, 16'h00FF);
      wr(3'd0, 16'h00FF);

      // Tick clear, clear against coincident edge, wrap
      wr(3'd5, 16'h0000);
      rd(3'd5, v); check("ticks_cleared", v, 16'h0000);
      irq_src = 8'h01;
      wr(3'd5, 16'h1234);
      irq_src = 8'h00;
      rd(3'd5, v); check("ticks_clear_vs_edge", v, 16'h0000);
      force dut.ticks = 16'hFFFE;
      #1;
      release dut.ticks;
      m_ticks = 16'hFFFE;
      pulse0();
      pulse0();
      rd(3'd5, v); check("ticks_wrap", v, 16'h0000);
      pulse0();
      rd(3'd5, v); check("ticks_after_wrap", v, 16'h0001);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         irq_src        = 8'($urandom);
         bus.chipselect = 1'($urandom_range(0, 1));
         bus.write_n    = 1'($urandom_range(0, 1));
         bus.address    = 3'($urandom_range(0, 7));
         bus.writedata  = (bus.address == 3'd4) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         reset          = ($urandom_range(0, 63) == 0);
         step();
      end
      reset          = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
